// File: rtl/arp_pkg.sv
// -----------------------------------------------------------------------------
// arp_pkg -- shared ARP definitions for the receive parser and the reply
// transmitter.
//
// Contents:
//   - ARP header field constants and payload lengths
//   - arp_tx_state_t : reply serialiser state encoding
//   - arp_req_t      : one captured request (requester and local addresses)
//   - helpers to find the last byte index of each state and to pick bytes
//
// Build option: ARP_PAD_EN adds the PAD state, which zero-fills the reply to
// the 46-byte Ethernet minimum payload.
// -----------------------------------------------------------------------------
package arp_pkg;

  localparam logic [15:0] ARP_HTYPE       = 16'h0001;
  localparam logic [15:0] ARP_PTYPE       = 16'h0800;
  localparam logic [7:0]  ARP_HLEN        = 8'h06;
  localparam logic [7:0]  ARP_PLEN        = 8'h04;
  localparam logic [15:0] ARP_OPER_RQ     = 16'h0001;
  localparam logic [15:0] ARP_OPER_RESP   = 16'h0002;
  localparam int          ARP_PAYLOAD_LEN = 28;
  localparam int          ETH_MIN_PAYLOAD = 46;

  // Fixed 8-byte reply header: HTYPE, PTYPE, HLEN, PLEN, OPER=reply.
  localparam logic [63:0] ARP_FIXED_HDR =
    {ARP_HTYPE, ARP_PTYPE, ARP_HLEN, ARP_PLEN, ARP_OPER_RESP};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIXED,
    ST_SHA,
    ST_SPA,
    ST_THA,
    ST_TPA
`ifdef ARP_PAD_EN
    ,
    ST_PAD
`endif
  } arp_tx_state_t;

  typedef struct packed {
    logic [47:0] req_mac;
    logic [31:0] req_ip;
    logic [47:0] local_mac;
    logic [31:0] local_ip;
  } arp_req_t;

  // Index of the final byte emitted in each state.
  function automatic logic [4:0] last_idx(arp_tx_state_t s);
    case (s)
      ST_FIXED: return 5'd7;
      ST_SHA:   return 5'd5;
      ST_SPA:   return 5'd3;
      ST_THA:   return 5'd5;
      ST_TPA:   return 5'd3;
`ifdef ARP_PAD_EN
      ST_PAD:   return 5'd17;
`endif
      default:  return 5'd0;
    endcase
  endfunction

  // Byte i of a left-aligned 64-bit word, counting from the MSB.
  function automatic logic [7:0] msb_byte(logic [63:0] w, logic [2:0] i);
    case (i)
      3'd0:    return w[63:56];
      3'd1:    return w[55:48];
      3'd2:    return w[47:40];
      3'd3:    return w[39:32];
      3'd4:    return w[31:24];
      3'd5:    return w[23:16];
      3'd6:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/arp_reply_tx.sv
// -----------------------------------------------------------------------------
// arp_reply_tx -- serialises an ARP reply payload (OPER=2) as a byte stream.
//
// Ports:
//   aclk, areset           clock, asynchronous active-high reset
//   arp_req_valid          one-cycle trigger from the ARP receive parser
//   req_mac, req_ip        requester addresses (become THA / TPA)
//   local_mac, local_ip    our addresses (become SHA / SPA), sampled on trigger
//   m_tdata/m_tvalid/m_tready/m_tlast  byte stream toward Ethernet TX framing
//   busy                   reply in flight or a request pending
//   req_drop               one-cycle pulse when a trigger is discarded
//
// Parameter PEND_DEPTH_EN: 1 keeps a one-deep pending request slot, 0 drops
// any trigger that arrives while busy.
// Build option: ARP_PAD_EN appends 18 zero bytes (46-byte payload, m_tlast on
// byte 45); without it the frame is 28 bytes and downstream pads.
// -----------------------------------------------------------------------------
module arp_reply_tx
  import arp_pkg::*;
#(
  parameter int PEND_DEPTH_EN = 1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        arp_req_valid,
  input  logic [47:0] req_mac,
  input  logic [31:0] req_ip,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        busy,
  output logic        req_drop
);

`ifdef ARP_PAD_EN
  localparam arp_tx_state_t FINAL_ST = ST_PAD;
`else
  localparam arp_tx_state_t FINAL_ST = ST_TPA;
`endif

  arp_tx_state_t state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  arp_req_t      act_q, act_d;
  arp_req_t      pend_q, pend_d;
  logic          pend_full_q, pend_full_d;
  logic          drop_q, drop_d;

  arp_req_t      trig;
  logic          idle, hs, last_beat, frame_end, promote;
  logic [63:0]   sel_word;

  assign trig      = '{req_mac: req_mac, req_ip: req_ip,
                       local_mac: local_mac, local_ip: local_ip};
  assign idle      = (state_q == ST_IDLE);
  assign hs        = m_tvalid & m_tready;
  assign last_beat = hs & (cnt_q == last_idx(state_q));
  assign frame_end = last_beat & (state_q == FINAL_ST);
  // The pending request starts as soon as the engine is free: on the edge that
  // completes the current frame, or from IDLE if it was parked there.
  assign promote   = pend_full_q & (idle | frame_end);

  // NOTE: every variable gets a default before any branch, so no path through
  // this block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    act_d       = act_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    drop_d      = 1'b0;

    if (last_beat) begin
      cnt_d = '0;
      case (state_q)
        ST_FIXED: state_d = ST_SHA;
        ST_SHA:   state_d = ST_SPA;
        ST_SPA:   state_d = ST_THA;
        ST_THA:   state_d = ST_TPA;
`ifdef ARP_PAD_EN
        ST_TPA:   state_d = ST_PAD;
`endif
        default:  state_d = ST_IDLE;
      endcase
    end else if (hs) begin
      cnt_d = cnt_q + 5'd1;
    end

    if (promote) begin
      act_d       = pend_q;
      state_d     = ST_FIXED;
      cnt_d       = '0;
      pend_full_d = 1'b0;
    end

    if (arp_req_valid) begin
      if (idle && !pend_full_q) begin
        act_d   = trig;
        state_d = ST_FIXED;
        cnt_d   = '0;
      end else if ((PEND_DEPTH_EN != 0) && (!pend_full_q || promote)) begin
        // Slot is free, or is being vacated by a promotion on this same edge.
        pend_d      = trig;
        pend_full_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_full_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_full_q <= pend_full_d;
      drop_q      <= drop_d;
    end
  end

  // NOTE: the address sets are wide data storage with no reset; they are only
  // observed while state_q or pend_full_q says they hold a valid request.
  always_ff @(posedge aclk) begin
    act_q  <= act_d;
    pend_q <= pend_d;
  end

  // Left-align the field of the current state; PAD and IDLE emit zero.
  always_comb begin
    sel_word = '0;
    case (state_q)
      ST_FIXED: sel_word = ARP_FIXED_HDR;
      ST_SHA:   sel_word = {act_q.local_mac, 16'h0000};
      ST_SPA:   sel_word = {act_q.local_ip, 32'h0000_0000};
      ST_THA:   sel_word = {act_q.req_mac, 16'h0000};
      ST_TPA:   sel_word = {act_q.req_ip, 32'h0000_0000};
      default:  sel_word = '0;
    endcase
  end

  assign m_tdata  = msb_byte(sel_word, cnt_q[2:0]);
  assign m_tvalid = !idle;
  assign m_tlast  = (state_q == FINAL_ST) && (cnt_q == last_idx(FINAL_ST));
  assign busy     = !idle | pend_full_q;
  assign req_drop = drop_q;

endmodule

// File: tb/tb_arp_reply_tx.sv
// -----------------------------------------------------------------------------
// tb_arp_reply_tx -- directed self-checking bench for arp_reply_tx.
// Honours ARP_PAD_EN: frame length and the zero tail follow the build option.
// -----------------------------------------------------------------------------
module tb_arp_reply_tx;

`ifdef ARP_PAD_EN
  localparam int FLEN = 46;
`else
  localparam int FLEN = 28;
`endif

  localparam logic [47:0] LM  = 48'h02_00_00_00_00_01;
  localparam logic [31:0] LI  = 32'hC0_A8_01_0A;        // 192.168.1.10
  localparam logic [47:0] RM  = 48'hAA_BB_CC_DD_EE_FF;
  localparam logic [31:0] RI  = 32'hC0_A8_01_14;        // 192.168.1.20
  localparam logic [31:0] RI2 = 32'h0A_00_00_05;        // 10.0.0.5
  localparam logic [31:0] RI3 = 32'h0A_00_00_09;        // 10.0.0.9
  // Hand-written reply for the first test case.
  localparam logic [223:0] T1_FRAME =
    224'h0001080006040002_020000000001_C0A8010A_AABBCCDDEEFF_C0A80114;

  logic        aclk, areset, arp_req_valid, m_tready;
  logic [47:0] req_mac, local_mac;
  logic [31:0] req_ip, local_ip;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, busy, req_drop;

  arp_reply_tx #(.PEND_DEPTH_EN(1)) dut (
    .aclk(aclk), .areset(areset), .arp_req_valid(arp_req_valid),
    .req_mac(req_mac), .req_ip(req_ip),
    .local_mac(local_mac), .local_ip(local_ip),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .busy(busy), .req_drop(req_drop)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int tests_run, tests_failed;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] rx_data[$];
  bit         rx_last[$];
  int         rx_cyc[$];
  int         cyc, drop_cnt, busy_low, stall_err;
  bit         ready_mode, prev_stall;
  logic [7:0] prev_data;

  // One clock cycle: drive m_tready, observe outputs away from the edge,
  // record the handshake that the coming edge will perform, then advance.
  task automatic tick();
    if (ready_mode) m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
    else            m_tready = 1'b1;
    if (prev_stall && m_tdata !== prev_data) stall_err++;
    if (m_tvalid && m_tready) begin
      rx_data.push_back(m_tdata);
      rx_last.push_back(m_tlast);
      rx_cyc.push_back(cyc);
    end
    if (req_drop) drop_cnt++;
    if (!busy) busy_low++;
    prev_stall = m_tvalid && !m_tready;
    prev_data  = m_tdata;
    cyc++;
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_rx();
    rx_data.delete();
    rx_last.delete();
    rx_cyc.delete();
    drop_cnt  = 0;
    busy_low  = 0;
    stall_err = 0;
  endtask

  task automatic trigger(input logic [47:0] rm, input logic [31:0] ri);
    req_mac       = rm;
    req_ip        = ri;
    arp_req_valid = 1'b1;
    tick();
    arp_req_valid = 1'b0;
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int b = 0;
    while (rx_data.size() < n && b < budget) begin
      tick();
      b++;
    end
    check({tag, "_rx_count"}, rx_data.size(), n);
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [47:0] lm,
      input logic [31:0] li, input logic [47:0] rm, input logic [31:0] ri);
    logic [223:0] f;
    f = {64'h0001_0800_0604_0002, lm, li, rm, ri};
    if (i >= 28) return 8'h00;
    return f[223 - 8*i -: 8];
  endfunction

  task automatic check_frame(input string tag, input int base,
      input logic [31:0] ri);
    int last_pos = -1;
    int n_last   = 0;
    for (int i = 0; i < FLEN; i++) begin
      check($sformatf("%s_byte%0d", tag, i), rx_data[base + i],
            exp_byte(i, LM, LI, RM, ri));
      if (rx_last[base + i]) begin
        n_last++;
        last_pos = i;
      end
    end
    check({tag, "_tlast_pos"}, last_pos, FLEN - 1);
    check({tag, "_tlast_cnt"}, n_last, 1);
  endtask

  initial begin
    logic [223:0] t1;
    int           trig_cyc;
    t1 = T1_FRAME;
    tests_run = 0; tests_failed = 0; cyc = 0;
    ready_mode = 1'b0; prev_stall = 1'b0; prev_data = '0;
    arp_req_valid = 1'b0; m_tready = 1'b1;
    req_mac = '0; req_ip = '0; local_mac = LM; local_ip = LI;
    areset = 1'b1;
    clear_rx();

    // Reset state
    tick(); tick();
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast",  m_tlast,  0);
    check("rst_busy",   busy,     0);
    check("rst_drop",   req_drop, 0);
    check("rst_tdata",  m_tdata,  0);
    areset = 1'b0;
    tick();

    // Single reply, continuous ready
    clear_rx();
    trig_cyc = cyc;
    trigger(RM, RI);
    check("t1_first_valid", m_tvalid, 1);
    check("t1_first_byte",  m_tdata,  8'h00);
    wait_rx("t1", FLEN, 200);
    check("t1_first_hs_cyc", rx_cyc[0], trig_cyc + 1);
    for (int i = 0; i < FLEN; i++)
      check($sformatf("t1_byte%0d", i), rx_data[i],
            (i < 28) ? t1[223 - 8*i -: 8] : 8'h00);
    check_frame("t1", 0, RI);
    tick(); tick();
    check("t1_idle_tvalid", m_tvalid, 0);
    check("t1_idle_busy",   busy,     0);

    // Backpressure: ready 1,0,0,1 repeating
    clear_rx();
    ready_mode = 1'b1;
    trigger(RM, RI);
    wait_rx("t2", FLEN, 400);
    repeat (8) tick();
    ready_mode = 1'b0;
    check("t2_handshakes", rx_data.size(), FLEN);
    check("t2_stall_stable", stall_err, 0);
    check_frame("t2", 0, RI);

    // Back-to-back: second trigger at byte 10 of frame 1
    clear_rx();
    trigger(RM, RI);
    busy_low = 0;
    wait_rx("t3a", 10, 100);
    trigger(RM, RI2);
    wait_rx("t3b", 2 * FLEN, 400);
    check("t3_busy_held", busy_low, 0);
    check("t3_gap", rx_cyc[FLEN] - rx_cyc[FLEN - 1], 1);
    check_frame("t3f1", 0, RI);
    check_frame("t3f2", FLEN, RI2);
    tick(); tick();
    check("t3_idle_busy", busy, 0);

    // Overflow: three triggers inside one frame
    clear_rx();
    trigger(RM, RI);
    wait_rx("t4a", 3, 100);
    trigger(RM, RI2);
    wait_rx("t4b", 6, 100);
    trigger(RM, RI3);
    check("t4_drop_pulse", req_drop, 1);
    repeat (3 * FLEN + 20) tick();
    check("t4_drop_cnt", drop_cnt, 1);
    check("t4_total_bytes", rx_data.size(), 2 * FLEN);
    check_frame("t4f2", FLEN, RI2);

    // Reset mid-frame with a request pending
    clear_rx();
    trigger(RM, RI);
    wait_rx("t5a", 5, 100);
    trigger(RM, RI2);
    wait_rx("t5b", 15, 100);
    #1 areset = 1'b1;
    #1;
    check("t5_rst_tvalid", m_tvalid, 0);
    check("t5_rst_busy",   busy,     0);
    check("t5_rst_tlast",  m_tlast,  0);
    @(posedge aclk);
    #1 areset = 1'b0;
    clear_rx();
    repeat (4) tick();
    check("t5_no_output", rx_data.size(), 0);
    check("t5_pend_clear", busy, 0);
    trigger(RM, RI);
    wait_rx("t5c", FLEN, 200);
    check_frame("t5", 0, RI);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
